// File: rtl/plane_fetch_scheduler.sv
// Per-line fetch scheduler for display planes A and B: shares one 16-bit memory
// read port between the planes and fills a small first-word-fall-through FIFO per plane.

module plane_fifo #(
  parameter int DEPTH = 16,
  parameter int CW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [15:0]   wdata,
  input  logic          pop,
  output logic [15:0]   data,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] rd;
  logic [AW-1:0] wr;
  logic [15:0]   hold;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign do_push = push && !flush;
  assign do_pop  = pop && !empty && !flush;
  // When empty the head shows the last word consumed, so a pop on empty leaves data untouched.
  assign data    = empty ? hold : mem[rd];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
      hold  <= '0;
    end else if (flush) begin
      wr    <= rd;
      count <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop) begin
        rd   <= rd + 1'b1;
        hold <= mem[rd];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module plane_fetch_scheduler #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 22
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              new_frame,
  input  logic              new_line,
  input  logic              display_active,
  input  logic              en_a,
  input  logic              en_b,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [8:0]        wpl_a,
  input  logic [8:0]        wpl_b,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  input  logic              pop_a,
  input  logic              pop_b,
  output logic [15:0]       data_a,
  output logic [15:0]       data_b,
  output logic              empty_a,
  output logic              empty_b,
  output logic              underrun,
  output logic              late
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state, state_next;
  logic              gnt;
  logic              rr;
  logic              stale;
  logic [ADDR_W-1:0] ptr_a, ptr_b;
  logic [8:0]        rem_a, rem_b;
  logic [8:0]        rem_eff_a, rem_eff_b;
  logic [CW-1:0]     count_a, count_b;
  logic              elig_a, elig_b;
  logic              ack_fire, ack_a, ack_b;
  logic              line_go, flush;
  logic              grant_go, grant_sel;

  function automatic logic [ADDR_W-1:0] next_ptr(
    input logic [ADDR_W-1:0] ptr,
    input logic [ADDR_W-1:0] base,
    input logic [8:0]        rem_eff,
    input logic              ack,
    input logic              frame,
    input logic              line
  );
    logic [ADDR_W-1:0] step;
    step = ack ? ADDR_W'(2) : '0;
    if (frame)     return base;
    else if (line) return ptr + {{(ADDR_W-10){1'b0}}, rem_eff, 1'b0} + step;
    else           return ptr + step;
  endfunction

  always_comb begin
    line_go   = new_line && display_active;
    flush     = new_line || new_frame;
    ack_fire  = (state == S_WAIT) && mem_ack;
    // A request overtaken by a line or frame start is already accounted for; its ack only retires it.
    ack_a     = ack_fire && !stale && !gnt;
    ack_b     = ack_fire && !stale && gnt;
    rem_eff_a = rem_a - {8'd0, ack_a};
    rem_eff_b = rem_b - {8'd0, ack_b};
    elig_a    = (rem_a != 9'd0) &&
                ((count_a + {{(CW-1){1'b0}}, (state == S_WAIT) && !gnt}) < DEPTH_C);
    elig_b    = (rem_b != 9'd0) &&
                ((count_b + {{(CW-1){1'b0}}, (state == S_WAIT) && gnt}) < DEPTH_C);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant_go   = 1'b0;
    grant_sel  = rr;
    case (state)
      S_IDLE: begin
        if (!flush && (elig_a || elig_b)) begin
          grant_go   = 1'b1;
          grant_sel  = (elig_a && elig_b) ? rr : elig_b;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_ack) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req  <= 1'b0;
      mem_addr <= '0;
      gnt      <= 1'b0;
      rr       <= 1'b0;
      stale    <= 1'b0;
      ptr_a    <= '0;
      ptr_b    <= '0;
      rem_a    <= '0;
      rem_b    <= '0;
      late     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (grant_go) begin
        mem_req  <= 1'b1;
        mem_addr <= grant_sel ? ptr_b : ptr_a;
        gnt      <= grant_sel;
        if (elig_a && elig_b) rr <= ~grant_sel;
      end else if (ack_fire) begin
        mem_req <= 1'b0;
      end

      if (ack_fire)                         stale <= 1'b0;
      else if ((state == S_WAIT) && flush)  stale <= 1'b1;

      ptr_a <= next_ptr(ptr_a, base_a, rem_eff_a, ack_a, new_frame, line_go);
      ptr_b <= next_ptr(ptr_b, base_b, rem_eff_b, ack_b, new_frame, line_go);

      if (flush)      rem_a <= (line_go && en_a) ? wpl_a : 9'd0;
      else if (ack_a) rem_a <= rem_a - 9'd1;
      if (flush)      rem_b <= (line_go && en_b) ? wpl_b : 9'd0;
      else if (ack_b) rem_b <= rem_b - 9'd1;

      if (new_frame) late <= 1'b0;
      else if (line_go && ((rem_eff_a != 9'd0) || (rem_eff_b != 9'd0))) late <= 1'b1;

      if (new_frame) underrun <= 1'b0;
      else if ((pop_a && empty_a) || (pop_b && empty_b)) underrun <= 1'b1;
    end
  end

  plane_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo_a (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (ack_a && !flush),
    .wdata (mem_rdata),
    .pop   (pop_a),
    .data  (data_a),
    .empty (empty_a),
    .count (count_a)
  );

  plane_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo_b (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (ack_b && !flush),
    .wdata (mem_rdata),
    .pop   (pop_b),
    .data  (data_b),
    .empty (empty_b),
    .count (count_b)
  );
endmodule
